// File: rtl/cpu_branch_pkg.sv
// Shared types and constants for the decode-stage branch resolver.
//   br_type_t  : ID_BrType encoding (B, B.cond, CBZ, CBNZ)
//   COND_*     : B.cond condition-field encodings
//   br_state_t : resolver FSM states
package cpu_branch_pkg;

  typedef enum logic [1:0] {
    B     = 2'b00,
    BCOND = 2'b01,
    CBZ   = 2'b10,
    CBNZ  = 2'b11
  } br_type_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;  // behaves as always, like AL

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator.
//   cond       : 4-bit condition field
//   n, z, v, c : effective NZVC flags
//   pass       : 1 when the condition holds
module cond_eval
  import cpu_branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~(c & ~z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = ~(~z & (n == v));
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Decode-stage branch resolver for the 5-stage LEGv8 pipeline.
// Holds the architectural NZVC register, resolves B / B.cond / CBZ / CBNZ
// in ID using same-cycle forwarded EX flags, and produces redirect, IF/ID
// flush and load-use stall, plus saturating branch statistics.
//   Inputs : ID_* decode-stage branch info, EX_* execute-stage flags and
//            register-write info.
//   Outputs: BrTaken/BrTarget redirect, Stall, Flush, FlagN/Z/V/C,
//            BrCount/TakenCount, dbg_state (current FSM state).
// Pipeline control semantics: Stall holds PC and IF/ID and bubbles ID/EX
// for exactly one cycle per branch; Flush and BrTaken are asserted together
// in the resolve cycle and the following cycle ignores ID (its content is
// the squashed wrong-path fetch).
module branch_resolver
  import cpu_branch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_BrValid,
  input  logic [1:0]       ID_BrType,
  input  logic [3:0]       ID_Cond,
  input  logic [4:0]       ID_CbzReg,
  input  logic [63:0]      ID_CbzVal,
  input  logic [63:0]      ID_PC,
  input  logic [63:0]      ID_BrOffset,
  input  logic             EX_SetFlags,
  input  logic             EX_negative,
  input  logic             EX_zero,
  input  logic             EX_overflow,
  input  logic             EX_carryout,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_destReg,
  output logic             BrTaken,
  output logic [63:0]      BrTarget,
  output logic             Stall,
  output logic             Flush,
  output logic             FlagN,
  output logic             FlagZ,
  output logic             FlagV,
  output logic             FlagC,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] TakenCount,
  output br_state_t        dbg_state
);

  br_state_t        state, state_next;
  logic             flag_n, flag_z, flag_v, flag_c;
  logic             eff_n, eff_z, eff_v, eff_c;
  logic             cond_pass, hz, taken, resolve;
  logic [CNT_W-1:0] br_count, taken_count;

  // Same-cycle forward from EX wins over the stored flags.
  assign eff_n = EX_SetFlags ? EX_negative : flag_n;
  assign eff_z = EX_SetFlags ? EX_zero     : flag_z;
  assign eff_v = EX_SetFlags ? EX_overflow : flag_v;
  assign eff_c = EX_SetFlags ? EX_carryout : flag_c;

  cond_eval u_cond_eval (
    .cond (ID_Cond),
    .n    (eff_n),
    .z    (eff_z),
    .v    (eff_v),
    .c    (eff_c),
    .pass (cond_pass)
  );

  // CBZ/CBNZ whose source is still being produced in EX; XZR never waits.
  assign hz = ID_BrValid & ID_BrType[1] & EX_RegWrite &
              (EX_destReg == ID_CbzReg) & (ID_CbzReg != 5'd31);

  always_comb begin
    taken = 1'b0;
    unique case (br_type_t'(ID_BrType))
      B:       taken = 1'b1;
      BCOND:   taken = cond_pass;
      CBZ:     taken = (ID_CbzVal == 64'd0);
      CBNZ:    taken = (ID_CbzVal != 64'd0);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    Stall      = 1'b0;
    BrTaken    = 1'b0;
    Flush      = 1'b0;
    resolve    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hz) begin
          Stall      = 1'b1;
          state_next = STALL;
        end else begin
          resolve = ID_BrValid;
        end
      end
      // Hazard ignored here so a branch never stalls twice.
      STALL: begin
        resolve    = ID_BrValid;
        state_next = IDLE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (resolve && taken) begin
      BrTaken    = 1'b1;
      Flush      = 1'b1;
      state_next = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      flag_v      <= 1'b0;
      flag_c      <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      state <= state_next;
      // EX always advances, so flags load regardless of FSM state.
      if (EX_SetFlags) begin
        flag_n <= EX_negative;
        flag_z <= EX_zero;
        flag_v <= EX_overflow;
        flag_c <= EX_carryout;
      end
      if (resolve && (br_count != '1))
        br_count <= br_count + CNT_W'(1);
      if (resolve && taken && (taken_count != '1))
        taken_count <= taken_count + CNT_W'(1);
    end
  end

  assign BrTarget   = ID_PC + ID_BrOffset;
  assign FlagN      = flag_n;
  assign FlagZ      = flag_z;
  assign FlagV      = flag_v;
  assign FlagC      = flag_c;
  assign BrCount    = br_count;
  assign TakenCount = taken_count;
  assign dbg_state  = state;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed steps followed by random cycles,
// each cycle compared against a behavioural model of the branch rules.
module tb_branch_resolver;
  import cpu_branch_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             ID_BrValid;
  logic [1:0]       ID_BrType;
  logic [3:0]       ID_Cond;
  logic [4:0]       ID_CbzReg;
  logic [63:0]      ID_CbzVal, ID_PC, ID_BrOffset;
  logic             EX_SetFlags, EX_negative, EX_zero, EX_overflow, EX_carryout;
  logic             EX_RegWrite;
  logic [4:0]       EX_destReg;
  logic             BrTaken, Stall, Flush, FlagN, FlagZ, FlagV, FlagC;
  logic [63:0]      BrTarget;
  logic [CNT_W-1:0] BrCount, TakenCount;
  br_state_t        dbg_state;

  branch_resolver #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_BrValid(ID_BrValid), .ID_BrType(ID_BrType), .ID_Cond(ID_Cond),
    .ID_CbzReg(ID_CbzReg), .ID_CbzVal(ID_CbzVal), .ID_PC(ID_PC),
    .ID_BrOffset(ID_BrOffset), .EX_SetFlags(EX_SetFlags),
    .EX_negative(EX_negative), .EX_zero(EX_zero), .EX_overflow(EX_overflow),
    .EX_carryout(EX_carryout), .EX_RegWrite(EX_RegWrite), .EX_destReg(EX_destReg),
    .BrTaken(BrTaken), .BrTarget(BrTarget), .Stall(Stall), .Flush(Flush),
    .FlagN(FlagN), .FlagZ(FlagZ), .FlagV(FlagV), .FlagC(FlagC),
    .BrCount(BrCount), .TakenCount(TakenCount), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  // reference model state
  bit m_n, m_z, m_v, m_c;
  int m_br, m_tk;
  bit m_stalled, m_flushing;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ref(input logic [3:0] cc, input bit n, z, v, c);
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !(c && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ID_BrValid = 0; ID_BrType = 0; ID_Cond = 0; ID_CbzReg = 0;
    ID_CbzVal = 0; ID_PC = 0; ID_BrOffset = 0;
    EX_SetFlags = 0; EX_negative = 0; EX_zero = 0; EX_overflow = 0;
    EX_carryout = 0; EX_RegWrite = 0; EX_destReg = 0;
  endtask

  task automatic drive_br(input logic [1:0] t, input logic [3:0] cc, input logic [4:0] rn,
                          input logic [63:0] val, input logic [63:0] pc, input logic [63:0] off);
    ID_BrValid = 1; ID_BrType = t; ID_Cond = cc; ID_CbzReg = rn;
    ID_CbzVal = val; ID_PC = pc; ID_BrOffset = off;
  endtask

  // nzvc = {N, Z, V, C}
  task automatic drive_ex(input logic setf, input logic [3:0] nzvc,
                          input logic rw, input logic [4:0] dest);
    EX_SetFlags = setf;
    {EX_negative, EX_zero, EX_overflow, EX_carryout} = nzvc;
    EX_RegWrite = rw; EX_destReg = dest;
  endtask

  // One cycle: compare combinational outputs on the falling edge, advance
  // the model on the rising edge, then compare registered outputs.
  task automatic step(input string tag);
    bit en, ez, ev, ec, hz, tk, e_stall, e_taken, e_flush, do_br, n_stalled, n_flushing;
    @(negedge clk);
    en = EX_SetFlags ? EX_negative : m_n;
    ez = EX_SetFlags ? EX_zero     : m_z;
    ev = EX_SetFlags ? EX_overflow : m_v;
    ec = EX_SetFlags ? EX_carryout : m_c;
    e_stall = 0; e_taken = 0; e_flush = 0; do_br = 0; tk = 0;
    n_stalled = 0; n_flushing = 0;
    if (!m_flushing) begin
      hz = ID_BrValid && ID_BrType[1] && EX_RegWrite && (EX_destReg == ID_CbzReg)
           && (ID_CbzReg != 5'd31) && !m_stalled;
      if (hz) begin
        e_stall = 1; n_stalled = 1;
      end else if (ID_BrValid) begin
        case (ID_BrType)
          2'd0: tk = 1;
          2'd1: tk = cond_ref(ID_Cond, en, ez, ev, ec);
          2'd2: tk = (ID_CbzVal == 64'd0);
          default: tk = (ID_CbzVal != 64'd0);
        endcase
        do_br = 1;
        if (tk) begin e_taken = 1; e_flush = 1; n_flushing = 1; end
      end
    end
    if (!reset) begin
      check({tag, ".stall"}, Stall, e_stall);
      check({tag, ".taken"}, BrTaken, e_taken);
      check({tag, ".flush"}, Flush, e_flush);
      if (e_taken) begin
        exp_q.push_back(ID_PC + ID_BrOffset);
        check({tag, ".target"}, BrTarget, exp_q.pop_front());
      end
    end
    @(posedge clk);
    if (reset) begin
      m_n = 0; m_z = 0; m_v = 0; m_c = 0; m_br = 0; m_tk = 0;
      m_stalled = 0; m_flushing = 0;
    end else begin
      if (EX_SetFlags) begin
        m_n = EX_negative; m_z = EX_zero; m_v = EX_overflow; m_c = EX_carryout;
      end
      if (do_br) m_br = sat_inc(m_br);
      if (do_br && tk) m_tk = sat_inc(m_tk);
      m_stalled = n_stalled; m_flushing = n_flushing;
    end
    #1;
    check({tag, ".flags"}, {FlagN, FlagZ, FlagV, FlagC}, {m_n, m_z, m_v, m_c});
    check({tag, ".brcount"}, BrCount, 64'(m_br));
    check({tag, ".takencount"}, TakenCount, 64'(m_tk));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [4:0] r;
    m_n = 0; m_z = 0; m_v = 0; m_c = 0; m_br = 0; m_tk = 0;
    m_stalled = 0; m_flushing = 0;

    // Reset with flags and a branch presented
    reset = 1;
    drive_idle();
    drive_ex(1, 4'hF, 0, 0);
    drive_br(B, COND_EQ, 0, 0, 64'h100, 64'h4);
    step("rst0");
    step("rst1");
    check("rst.flags", {FlagN, FlagZ, FlagV, FlagC}, 4'b0000);
    check("rst.brcount", BrCount, 0);
    check("rst.takencount", TakenCount, 0);
    reset = 0;
    drive_idle();
    #2;
    check("rst.idle_out", {Stall, Flush, BrTaken}, 3'b000);
    step("idle");

    // Reset during STALL abandons it
    drive_ex(0, 4'h0, 1, 5);
    drive_br(CBZ, 0, 5, 0, 64'h200, 64'h10);
    step("rs.stall");
    reset = 1;
    step("rs.reset");
    check("rs.state", dbg_state, IDLE);
    reset = 0;
    #2;
    check("rs.stall_again", Stall, 1);
    step("rs.after");
    drive_idle();
    step("rs.drain");

    // Flag forward into B.cond EQ
    reset = 1; drive_idle(); step("t2.rst"); reset = 0;
    drive_ex(1, 4'b0100, 0, 0);
    drive_br(BCOND, COND_EQ, 0, 0, 64'h1000, 64'h40);
    #2;
    check("t2.taken", BrTaken, 1);
    check("t2.target", BrTarget, 64'h1040);
    check("t2.flush", Flush, 1);
    step("t2");
    check("t2.flagz", FlagZ, 1);
    check("t2.takencount", TakenCount, 1);
    drive_idle();
    drive_br(B, 0, 0, 0, 64'h2000, 64'h8);
    #2;
    check("t2.ignored", BrTaken, 0);
    step("t2.flushcyc");
    check("t2.brcount", BrCount, 1);
    drive_idle();
    step("t2.drain");

    // Condition sweep: 16 codes x 16 flag combos
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        drive_idle();
        drive_ex(1, 4'(f), 0, 0);
        drive_br(BCOND, 4'(cc), 0, 0, 64'h4000 + 64'(cc * 64 + f * 4), 64'h100);
        step("sweep");
        drive_idle();
        step("sweep.drain");
      end
    end
    drive_idle(); drive_ex(1, 4'b1010, 0, 0); drive_br(BCOND, COND_GT, 0, 0, 64'h0, 64'h0);
    #2; check("gt.n1v1z0", BrTaken, 1); step("gt"); drive_idle(); step("gt.drain");
    drive_idle(); drive_ex(1, 4'b0010, 0, 0); drive_br(BCOND, COND_LT, 0, 0, 64'h0, 64'h0);
    #2; check("lt.n0v1", BrTaken, 1); step("lt"); drive_idle(); step("lt.drain");
    drive_idle(); drive_ex(1, 4'b0000, 0, 0); drive_br(BCOND, COND_NV, 0, 0, 64'h0, 64'h0);
    #2; check("nv.always", BrTaken, 1); step("nv"); drive_idle(); step("nv.drain");

    // Load-use stall on CBZ
    reset = 1; drive_idle(); step("t4.rst"); reset = 0;
    drive_ex(0, 4'h0, 1, 5);
    drive_br(CBZ, 0, 5, 64'h0, 64'h3000, 64'h20);
    #2;
    check("t4.stall", Stall, 1);
    check("t4.nottaken", BrTaken, 0);
    step("t4.s");
    #2;
    check("t4.nostall2", Stall, 0);
    check("t4.taken", BrTaken, 1);
    step("t4.r");
    check("t4.brcount", BrCount, 1);
    drive_idle(); step("t4.drain");
    drive_ex(0, 4'h0, 1, 31);
    drive_br(CBZ, 0, 31, 64'h0, 64'h3100, 64'h20);
    #2;
    check("t4.xzr_nostall", Stall, 0);
    step("t4.xzr");
    drive_idle(); step("t4.xzr_drain");
    check("t4.xzr_brcount", BrCount, 2);

    // CBNZ not taken
    drive_br(CBNZ, 0, 3, 64'h0, 64'h3200, 64'h20);
    #2;
    check("t5.nottaken", BrTaken, 0);
    step("t5");
    check("t5.brcount", BrCount, 3);
    check("t5.takencount", TakenCount, 2);
    check("t5.state", dbg_state, IDLE);

    // Target wrap and counter saturation
    drive_idle();
    drive_br(B, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8);
    #2;
    check("t6.wrap", BrTarget, 64'h4);
    step("t6.wrap");
    drive_idle(); step("t6.drain");
    for (int i = 0; i < 20; i++) begin
      drive_br(B, 0, 0, 0, 64'(i * 8), 64'h40);
      step("t6.sat");
      drive_idle();
      step("t6.sat_drain");
    end
    check("t6.takensat", TakenCount, 15);
    check("t6.brsat", BrCount, 15);

    // Random traffic
    reset = 1; drive_idle(); step("rnd.rst"); reset = 0;
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      ID_BrValid  = ($urandom_range(0, 9) < 6);
      ID_BrType   = 2'($urandom_range(0, 3));
      ID_Cond     = 4'($urandom_range(0, 15));
      r           = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      ID_CbzReg   = r;
      ID_CbzVal   = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom};
      ID_PC       = {$urandom, $urandom};
      ID_BrOffset = {$urandom, $urandom};
      EX_SetFlags = 1'($urandom_range(0, 1));
      EX_negative = 1'($urandom_range(0, 1));
      EX_zero     = 1'($urandom_range(0, 1));
      EX_overflow = 1'($urandom_range(0, 1));
      EX_carryout = 1'($urandom_range(0, 1));
      EX_RegWrite = 1'($urandom_range(0, 1));
      r           = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      EX_destReg  = r;
      step("rand");
    end
    reset = 0;

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
